ste_dma_audio: RTL and testbench
================================

STE_DMA_AUDIO -- requirements
Module: ste_dma_audio

Interface
REQ-001 SHALL have parameter FIFO_ADDR_BITS, default 3, log2 of FIFO depth (DEPTH = 2^FIFO_ADDR_BITS words).
REQ-002 SHALL have parameter BASE_DIV, default 640, clk32 cycles per base tick (50 kHz at 32 MHz).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk32  in  1  sole clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 mode_wr  in  1  one-cycle strobe that loads mode_din.
REQ-007 mode_din  in  4  bits 1:0 rate (3=50k, 2=25k, 1=12.5k, 0=6.25k); bit 2 mono; bit 3 fmt16.
REQ-008 enable  in  1  playback enable.
REQ-009 flush  in  1  synchronous FIFO clear.
REQ-010 SLOAD_N  in  1  DMA load strobe, active low; falling edge writes MDIN.
REQ-011 MDIN  in  16  DMA data word.
REQ-012 SREQ  out  1  DMA request.
REQ-013 audio_left, audio_right  out  16 each  offset-binary samples.
REQ-014 level  out  FIFO_ADDR_BITS+1  FIFO occupancy, 0..DEPTH.
REQ-015 underrun, overflow  out  1 each  one-cycle event pulses.

Function
REQ-016 FIFO SHALL hold the full DEPTH words, using pointers one bit wider than FIFO_ADDR_BITS.
REQ-017 Load detect SHALL be a registered SLOAD_N (sload_d): write when sload_d=1 and SLOAD_N=0; level updates the following cycle.
REQ-018 SREQ SHALL be high when level <= DEPTH-2, leaving room for one in-flight load.
REQ-019 Load at level=DEPTH SHALL drop the word, keep pointers, and pulse overflow.
REQ-020 Base counter SHALL count 0..BASE_DIV-1 and wrap; tick when count=BASE_DIV-1.
REQ-021 3-bit rate counter SHALL increment on each tick; sample strobe on a tick when rate 3: always; rate 2: cnt[0]=0; rate 1: cnt[1:0]=0; rate 0: cnt=0.
REQ-022 On strobe with enable=1, consumption by mode:
 - stereo8: needs 1 word; L=hi byte, R=lo byte; pop 1.
 - mono8: needs 1 word; both=hi byte if phase=0, else lo byte; toggle phase; pop only when phase goes 1->0.
 - stereo16: needs 2 words; L=first, R=second; pop 2.
 - mono16: needs 1 word; both=word; pop 1.
REQ-023 Output format: 8-bit sample s -> {s^8'h80, 8'h00}; 16-bit sample w -> w^16'h8000; outputs register at strobe+1 cycle.
REQ-024 Strobe with insufficient words SHALL hold outputs and byte phase, and pulse underrun once.
REQ-025 enable=0 SHALL suppress consumption and underrun; loads still accepted.
REQ-026 Simultaneous load and pop SHALL give level = level + 1 - pops.
REQ-027 flush SHALL zero pointers and byte phase and leave outputs unchanged; flush beats a coincident load (word dropped, no overflow).
REQ-028 mode_wr SHALL apply from the next strobe, clear byte phase, and leave the rate counter running.

Reset
REQ-029 rst SHALL clear pointers, byte phase, base and rate counters, mode (=0), sload_d (set to 1); audio_left/right=16'h8000; underrun/overflow=0; hence SREQ=1 and level=0.
REQ-030 rst mid-transfer SHALL discard FIFO contents; no pulse SHALL emit on the first cycle after release.

Structure
REQ-031 Shared package ste_audio_pkg SHALL hold the rate encodings, mode_din bit indices and the 16'h8000 midscale constant.
REQ-032 FIFO storage and pointers SHALL be a sub-module audio_fifo (parameter ADDR_BITS; write, pop count 0..2, flush, level).

Verification
REQ-033 Defaults, stereo8, rate 3: load 16'h7F80 -> at the next strobe L=16'hFF00, R=16'h0000; level 1->0.
REQ-034 mono8, rate 3: load 16'h0102 -> strobe1 both=16'h8100, strobe2 both=16'h8200; pop only after strobe2.
REQ-035 stereo16 with one word queued -> strobe gives underrun pulse and outputs hold 16'h8000; a second load 16'h0000 then strobe -> L=first^16'h8000, R=16'h8000.
REQ-036 Fill 7 words (DEPTH=8) -> SREQ=0 from level 7; 8th load accepted (level 8); 9th load -> overflow pulse, level stays 8.
REQ-037 flush coincident with a load at level 3 -> level 0, SREQ=1, no overflow, outputs unchanged.
REQ-038 rate 0, enable=1, FIFO kept fed -> strobes exactly 8*640=5120 cycles apart; rst asserted mid-run -> outputs 16'h8000 asynchronously.

Source files
------------

// File: rtl/ste_audio_pkg.sv
// Shared constants and types for the STE DMA sound block.
// Rate codes, mode register layout and sample formatting.
package ste_audio_pkg;

  localparam logic [1:0] RATE_50K  = 2'd3;
  localparam logic [1:0] RATE_25K  = 2'd2;
  localparam logic [1:0] RATE_12K5 = 2'd1;
  localparam logic [1:0] RATE_6K25 = 2'd0;

  localparam int MODE_RATE_LO = 0;
  localparam int MODE_RATE_HI = 1;
  localparam int MODE_MONO    = 2;
  localparam int MODE_FMT16   = 3;

  localparam logic [15:0] MIDSCALE = 16'h8000;

  typedef struct packed {
    logic       fmt16;
    logic       mono;
    logic [1:0] rate;
  } mode_t;

  function automatic mode_t to_mode(input logic [3:0] din);
    mode_t m;
    m.fmt16 = din[MODE_FMT16];
    m.mono  = din[MODE_MONO];
    m.rate  = din[MODE_RATE_HI:MODE_RATE_LO];
    return m;
  endfunction

  // Signed 8-bit PCM to left-justified offset binary.
  function automatic logic [15:0] fmt8(input logic [7:0] s);
    return {s ^ 8'h80, 8'h00};
  endfunction

endpackage

// File: rtl/audio_fifo.sv
// Sample word FIFO with one-bit-wider pointers so all 2^ADDR_BITS slots are usable.
// Pops 0..2 words per cycle; flush wins over any write.
module audio_fifo #(
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_i,
  input  logic [15:0]          wdata_i,
  input  logic [1:0]           pop_i,
  input  logic                 flush_i,
  output logic [15:0]          rdata0_o,
  output logic [15:0]          rdata1_o,
  output logic [ADDR_BITS:0]   level_o,
  output logic                 dropped_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [15:0]          mem_q [DEPTH];
  logic [ADDR_BITS:0]   wptr_q, wptr_d;
  logic [ADDR_BITS:0]   rptr_q, rptr_d;
  logic [ADDR_BITS-1:0] ridx0, ridx1;
  logic                 full;
  logic                 do_wr;

  assign ridx0 = rptr_q[ADDR_BITS-1:0];
  assign ridx1 = ridx0 + ADDR_BITS'(1);

  assign full = (wptr_q[ADDR_BITS] != rptr_q[ADDR_BITS]) &&
                (wptr_q[ADDR_BITS-1:0] == ridx0);

  assign do_wr     = wr_i & ~full & ~flush_i;
  assign dropped_o = wr_i & full & ~flush_i;

  assign level_o  = wptr_q - rptr_q;
  assign rdata0_o = mem_q[ridx0];
  assign rdata1_o = mem_q[ridx1];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q + (ADDR_BITS+1)'(pop_i);
    if (do_wr) wptr_d = wptr_q + (ADDR_BITS+1)'(1);
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[ADDR_BITS-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ste_dma_audio.sv
// STE-style DMA sound playback: DMA word FIFO, rate divider and
// 8/16-bit mono/stereo unpacking to offset-binary left/right samples.
module ste_dma_audio
  import ste_audio_pkg::*;
#(
  parameter int FIFO_ADDR_BITS = 3,
  parameter int BASE_DIV       = 640
) (
  input  logic                      clk32,
  input  logic                      rst,
  input  logic                      mode_wr,
  input  logic [3:0]                mode_din,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      SLOAD_N,
  input  logic [15:0]               MDIN,
  output logic                      SREQ,
  output logic [15:0]               audio_left,
  output logic [15:0]               audio_right,
  output logic [FIFO_ADDR_BITS:0]   level,
  output logic                      underrun,
  output logic                      overflow
);

  localparam int DEPTH = 1 << FIFO_ADDR_BITS;
  localparam int CW    = $clog2(BASE_DIV);
  localparam logic [FIFO_ADDR_BITS:0] SREQ_MAX = (FIFO_ADDR_BITS+1)'(DEPTH - 2);
  localparam logic [FIFO_ADDR_BITS:0] TWO      = (FIFO_ADDR_BITS+1)'(2);

  mode_t       mode_q, mode_d;
  logic        sload_q;
  logic [CW-1:0] base_q, base_d;
  logic [2:0]  rate_q, rate_d;
  logic        phase_q, phase_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic        ur_q, ur_d;
  logic        ov_q;

  logic        load, tick, rate_hit, act, have;
  logic        st8, mo8, st16, mo16;
  logic [1:0]  pop;
  logic [15:0] rd0, rd1;
  logic [7:0]  mbyte;
  logic        dropped;

  assign load = sload_q & ~SLOAD_N;

  audio_fifo #(
    .ADDR_BITS (FIFO_ADDR_BITS)
  ) u_fifo (
    .clk_i     (clk32),
    .rst_i     (rst),
    .wr_i      (load),
    .wdata_i   (MDIN),
    .pop_i     (pop),
    .flush_i   (flush),
    .rdata0_o  (rd0),
    .rdata1_o  (rd1),
    .level_o   (level),
    .dropped_o (dropped)
  );

  assign tick   = base_q == CW'(BASE_DIV - 1);
  assign base_d = tick ? '0 : base_q + CW'(1);
  assign rate_d = rate_q + {2'b00, tick};

  // Rate code selects how many base ticks elapse between samples.
  always_comb begin
    case (mode_q.rate)
      RATE_50K:  rate_hit = 1'b1;
      RATE_25K:  rate_hit = ~rate_q[0];
      RATE_12K5: rate_hit = rate_q[1:0] == 2'b00;
      default:   rate_hit = rate_q == 3'd0;
    endcase
  end

  assign st8  = ~mode_q.fmt16 & ~mode_q.mono;
  assign mo8  = ~mode_q.fmt16 &  mode_q.mono;
  assign st16 =  mode_q.fmt16 & ~mode_q.mono;
  assign mo16 =  mode_q.fmt16 &  mode_q.mono;

  assign act   = tick & rate_hit & enable & ~flush;
  assign have  = st16 ? (level >= TWO) : (level != '0);
  assign mbyte = phase_q ? rd0[7:0] : rd0[15:8];

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    phase_d = phase_q;
    pop     = 2'd0;
    ur_d    = 1'b0;
    if (act) begin
      if (!have) begin
        ur_d = 1'b1;
      end else begin
        unique case (1'b1)
          st8: begin
            left_d  = fmt8(rd0[15:8]);
            right_d = fmt8(rd0[7:0]);
            pop     = 2'd1;
          end
          mo8: begin
            left_d  = fmt8(mbyte);
            right_d = fmt8(mbyte);
            pop     = {1'b0, phase_q};
            phase_d = ~phase_q;
          end
          st16: begin
            left_d  = rd0 ^ MIDSCALE;
            right_d = rd1 ^ MIDSCALE;
            pop     = 2'd2;
          end
          mo16: begin
            left_d  = rd0 ^ MIDSCALE;
            right_d = rd0 ^ MIDSCALE;
            pop     = 2'd1;
          end
          default: ;
        endcase
      end
    end
    if (mode_wr || flush) phase_d = 1'b0;
  end

  assign mode_d = mode_wr ? to_mode(mode_din) : mode_q;

  always_ff @(posedge clk32 or posedge rst) begin
    if (rst) begin
      mode_q  <= '0;
      sload_q <= 1'b1;
      base_q  <= '0;
      rate_q  <= '0;
      phase_q <= 1'b0;
      left_q  <= MIDSCALE;
      right_q <= MIDSCALE;
      ur_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      sload_q <= SLOAD_N;
      base_q  <= base_d;
      rate_q  <= rate_d;
      phase_q <= phase_d;
      left_q  <= left_d;
      right_q <= right_d;
      ur_q    <= ur_d;
      ov_q    <= dropped;
    end
  end

  assign SREQ        = level <= SREQ_MAX;
  assign audio_left  = left_q;
  assign audio_right = right_q;
  assign underrun    = ur_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_ste_dma_audio.sv
// Bench for ste_dma_audio: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ste_dma_audio;

  localparam int AB    = 3;
  localparam int DEPTH = 8;
  localparam int BD    = 640;

  logic        clk32 = 1'b0;
  logic        rst = 1'b0;
  logic        mode_wr = 1'b0;
  logic [3:0]  mode_din = 4'h0;
  logic        enable = 1'b1;
  logic        flush = 1'b0;
  logic        SLOAD_N = 1'b1;
  logic [15:0] MDIN = 16'h0;
  logic        SREQ;
  logic [15:0] audio_left, audio_right;
  logic [AB:0] level;
  logic        underrun, overflow;

  always #5 clk32 = ~clk32;

  ste_dma_audio #(
    .FIFO_ADDR_BITS (AB),
    .BASE_DIV       (BD)
  ) dut (
    .clk32       (clk32),
    .rst         (rst),
    .mode_wr     (mode_wr),
    .mode_din    (mode_din),
    .enable      (enable),
    .flush       (flush),
    .SLOAD_N     (SLOAD_N),
    .MDIN        (MDIN),
    .SREQ        (SREQ),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .level       (level),
    .underrun    (underrun),
    .overflow    (overflow)
  );

  int cmp = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    cmp++;
    if (act != exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO as a queue, timing from absolute cycle arithmetic.
  logic [15:0] q[$];
  logic [15:0] m_l, m_r, w;
  logic [7:0]  b;
  logic [3:0]  m_mode;
  bit          m_phase, m_ur, m_ov, m_prev, ld, stb;
  int          m_cyc, strobes, sz, per;

  always @(posedge clk32 or posedge rst) begin
    if (rst) begin
      q.delete();
      m_l = 16'h8000; m_r = 16'h8000;
      m_mode = 4'h0; m_phase = 1'b0;
      m_ur = 1'b0; m_ov = 1'b0;
      m_prev = 1'b1; m_cyc = 0;
    end else begin
      ld  = m_prev && !SLOAD_N;
      per = 1 << (3 - int'(m_mode[1:0]));
      stb = ((m_cyc % BD) == BD - 1) && (((m_cyc / BD) % per) == 0);
      m_ur = 1'b0; m_ov = 1'b0;
      if (stb) strobes++;
      if (flush) begin
        q.delete();
        m_phase = 1'b0;
      end else begin
        sz = q.size();
        if (stb && enable) begin
          if (q.size() < ((m_mode[3] && !m_mode[2]) ? 2 : 1)) m_ur = 1'b1;
          else if (!m_mode[3] && !m_mode[2]) begin
            w = q.pop_front();
            m_l = {w[15:8] ^ 8'h80, 8'h00};
            m_r = {w[7:0] ^ 8'h80, 8'h00};
          end else if (!m_mode[3]) begin
            w = q[0];
            b = m_phase ? w[7:0] : w[15:8];
            m_l = {b ^ 8'h80, 8'h00};
            m_r = m_l;
            if (m_phase) void'(q.pop_front());
            m_phase = !m_phase;
          end else if (!m_mode[2]) begin
            m_l = q.pop_front() ^ 16'h8000;
            m_r = q.pop_front() ^ 16'h8000;
          end else begin
            m_l = q.pop_front() ^ 16'h8000;
            m_r = m_l;
          end
        end
        if (ld) begin
          if (sz == DEPTH) m_ov = 1'b1;
          else q.push_back(MDIN);
        end
      end
      if (mode_wr) begin
        m_mode = mode_din;
        m_phase = 1'b0;
      end
      m_prev = SLOAD_N;
      m_cyc++;
    end
  end

  always @(negedge clk32) begin
    if (chk_on && !rst) begin
      chk("level", int'(level), q.size());
      chk("SREQ", int'(SREQ), int'(q.size() <= DEPTH - 2));
      chk("audio_left", int'(audio_left), int'(m_l));
      chk("audio_right", int'(audio_right), int'(m_r));
      chk("underrun", int'(underrun), int'(m_ur));
      chk("overflow", int'(overflow), int'(m_ov));
    end
  end

  task automatic do_reset();
    @(negedge clk32);
    rst = 1'b1; SLOAD_N = 1'b1; flush = 1'b0; mode_wr = 1'b0; enable = 1'b1;
    @(negedge clk32);
    @(negedge clk32);
    rst = 1'b0;
    chk_on = 1'b1;
  endtask

  task automatic set_mode(input logic [3:0] m);
    @(negedge clk32);
    mode_wr = 1'b1; mode_din = m;
    @(negedge clk32);
    mode_wr = 1'b0;
  endtask

  task automatic load(input logic [15:0] d);
    @(negedge clk32);
    MDIN = d; SLOAD_N = 1'b0;
    @(negedge clk32);
    SLOAD_N = 1'b1;
  endtask

  task automatic wait_strobe(input int bound);
    int s0, n;
    s0 = strobes; n = 0;
    while (strobes == s0 && n < bound) begin
      @(negedge clk32);
      n++;
    end
    chk("strobe_seen", int'(strobes != s0), 1);
  endtask

  int t[3];
  logic [15:0] last;
  logic [1:0] rr;

  initial begin
    do_reset();
    chk("rst_left", int'(audio_left), 16'h8000);
    chk("rst_level", int'(level), 0);
    chk("rst_sreq", int'(SREQ), 1);

    // stereo8 at 50 kHz
    set_mode(4'b0011);
    load(16'h7F80);
    chk("st8_lvl1", int'(level), 1);
    wait_strobe(2000);
    chk("st8_L", int'(audio_left), 16'hFF00);
    chk("st8_R", int'(audio_right), 16'h0000);
    chk("st8_lvl0", int'(level), 0);

    // mono8 byte sequencing
    do_reset();
    set_mode(4'b0111);
    load(16'h0102);
    wait_strobe(2000);
    chk("mo8_s1", int'(audio_left), 16'h8100);
    chk("mo8_s1R", int'(audio_right), 16'h8100);
    chk("mo8_lvl1", int'(level), 1);
    wait_strobe(2000);
    chk("mo8_s2", int'(audio_left), 16'h8200);
    chk("mo8_lvl0", int'(level), 0);

    // stereo16 underrun then completion
    do_reset();
    set_mode(4'b1011);
    load(16'h1234);
    wait_strobe(2000);
    chk("st16_ur", int'(underrun), 1);
    chk("st16_hold", int'(audio_left), 16'h8000);
    chk("st16_lvl", int'(level), 1);
    load(16'h0000);
    wait_strobe(2000);
    chk("st16_L", int'(audio_left), 16'h9234);
    chk("st16_R", int'(audio_right), 16'h8000);

    // fill to full and overflow
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) load(16'(i + 1));
    chk("fill_sreq6", int'(SREQ), 1);
    load(16'h0007);
    chk("fill_sreq7", int'(SREQ), 0);
    chk("fill_lvl7", int'(level), 7);
    load(16'h0008);
    chk("fill_lvl8", int'(level), 8);
    chk("fill_no_ov", int'(overflow), 0);
    load(16'h0009);
    chk("fill_ov", int'(overflow), 1);
    chk("fill_lvl8b", int'(level), 8);

    // flush beats a coincident load
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) load(16'hA0A0);
    chk("fl_lvl3", int'(level), 3);
    @(negedge clk32);
    MDIN = 16'h5555; SLOAD_N = 1'b0; flush = 1'b1;
    @(negedge clk32);
    SLOAD_N = 1'b1; flush = 1'b0;
    chk("fl_lvl0", int'(level), 0);
    chk("fl_sreq", int'(SREQ), 1);
    chk("fl_ov", int'(overflow), 0);
    chk("fl_out", int'(audio_left), 16'h8000);

    // 6.25 kHz spacing and asynchronous reset
    do_reset();
    set_mode(4'b1100);
    load(16'h1111); load(16'h2222); load(16'h3333);
    last = audio_left;
    begin
      int c, n;
      c = 0;
      for (int s = 0; s < 3; s++) begin
        n = 0;
        while (audio_left == last && n < 6000) begin
          @(negedge clk32);
          n++; c++;
        end
        chk("r0_change", int'(audio_left != last), 1);
        last = audio_left;
        t[s] = c;
      end
    end
    chk("r0_L3", int'(audio_left), 16'hB333);
    chk("r0_gap1", t[1] - t[0], 5120);
    chk("r0_gap2", t[2] - t[1], 5120);
    @(negedge clk32);
    #1 rst = 1'b1;
    #1;
    chk("arst_L", int'(audio_left), 16'h8000);
    chk("arst_R", int'(audio_right), 16'h8000);
    chk("arst_lvl", int'(level), 0);
    @(negedge clk32);
    rst = 1'b0;

    // randomized traffic
    do_reset();
    set_mode(4'b0011);
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk32);
      SLOAD_N = ($urandom_range(0, 319) == 0) ? 1'b0 : 1'b1;
      MDIN    = 16'($urandom);
      flush   = ($urandom_range(0, 2999) == 0);
      enable  = ($urandom_range(0, 19) != 0);
      mode_wr = ($urandom_range(0, 1999) == 0);
      rr      = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd3;
      mode_din = {2'($urandom_range(0, 3)), rr};
    end
    @(negedge clk32);
    SLOAD_N = 1'b1; flush = 1'b0; mode_wr = 1'b0;
    @(negedge clk32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
